// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - bin one bit per clock, LSB first,
// and presents diff/bout/ovf as registered results with a single-cycle done.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             a0_c;
    logic             b0_c;
    logic             d_c;
    logic             brw_next_c;
    logic             last_c;

    // One-bit full-subtractor slice on the current LSBs and borrow
    always_comb begin
        a0_c       = a_sh[0];
        b0_c       = b_sh[0];
        d_c        = a0_c ^ b0_c ^ brw;
        brw_next_c = (~a0_c & b0_c) | (~(a0_c ^ b0_c) & brw);
        last_c     = (cnt == CW'(WIDTH - 1));
    end

    // Control FSM, datapath shift registers and registered results
    always_ff @(posedge CLK) begin
        if (R) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        brw   <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {d_c, res_sh[WIDTH-1:1]};
                    brw    <= brw_next_c;
                    cnt    <= cnt + CW'(1);
                    if (last_c) begin
                        // brw here is the borrow into the MSB slice
                        diff  <= {d_c, res_sh[WIDTH-1:1]};
                        bout  <= brw_next_c;
                        ovf   <= brw ^ brw_next_c;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits, legal range 2..64.
REQ-002 SHALL have port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: R  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 SHALL have port: A  input  WIDTH  minuend; captured on accepted start.
REQ-006 SHALL have port: B  input  WIDTH  subtrahend; captured on accepted start.
REQ-007 SHALL have port: bin  input  1  initial borrow-in; captured on accepted start.
REQ-008 SHALL have port: busy  output  1  high in RUN and DONE states.
REQ-009 SHALL have port: done  output  1  single-cycle pulse, high only in DONE state.
REQ-010 SHALL have port: diff  output  WIDTH  registered result of A-B-bin, modulo 2^WIDTH.
REQ-011 SHALL have port: bout  output  1  registered final borrow out of MSB.
REQ-012 SHALL have port: ovf  output  1  registered two's-complement overflow flag.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE: on start=1, SHALL load A and B into operand shift registers, load the borrow flip-flop with bin, clear the bit counter, and go to RUN; start=0 stays in IDLE.
REQ-015 RUN: each edge SHALL process one bit, LSB first, using a0, b0 and borrow brw.
  - d = a0 ^ b0 ^ brw
  - brw_next = (~a0 & b0) | (~(a0 ^ b0) & brw)
  - d shifts into the MSB of the internal result shift register; the operand registers shift right one bit.
REQ-016 The bit counter SHALL be clog2(WIDTH) bits wide and increment once per RUN edge; RUN SHALL last exactly WIDTH edges.
REQ-017 On the RUN edge that processes bit WIDTH-1 (counter == WIDTH-1), the FSM SHALL go to DONE.
REQ-018 On that same edge, diff, bout and ovf SHALL be updated together.
  - diff takes the completed result.
  - bout takes brw_next.
  - ovf = (borrow into MSB) XOR (borrow out of MSB).
REQ-019 DONE SHALL last exactly one cycle, with done=1, and then return to IDLE unconditionally.
REQ-020 Latency: with the start-capture edge counted as edge 1, done SHALL be high in the cycle after edge WIDTH+1; the next start can be accepted at edge WIDTH+3.
REQ-021 start SHALL be ignored in RUN and DONE; no queuing.
REQ-022 Operand changes on A, B and bin after capture SHALL NOT affect the operation in progress.
REQ-023 diff, bout and ovf SHALL hold their values from completion until the next operation completes; they SHALL NOT change during RUN.
REQ-024 If start is held high continuously, a new operation SHALL be accepted at each IDLE visit, giving one result every WIDTH+2 cycles.

Reset
REQ-025 R=1 at a rising edge SHALL force state IDLE and clear to 0: busy, done, diff, bout, ovf, the borrow flip-flop, the counter and the shift registers.
REQ-026 R SHALL take priority over start and over any in-flight operation.
REQ-027 After a mid-operation reset, the abandoned operation SHALL produce no done pulse and no result update.
REQ-028 The first start after R deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-029 Basic subtraction: A=0x5A, B=0x23, bin=0 -> diff=0x37, bout=0, ovf=0.
  - done pulses exactly once, in the cycle after edge 9.
  - busy is high for 9 cycles.
REQ-030 Unsigned underflow: A=0x00, B=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0.
REQ-031 Signed overflow: A=0x80, B=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
REQ-032 Borrow-in: A=0x10, B=0x10, bin=1 -> diff=0xFF, bout=1, ovf=0.
REQ-033 Reset mid-operation: R=1 for one cycle on the 4th RUN edge -> busy=0 and diff/bout/ovf=0 the next cycle, and no done pulse.
  - A following start with A=0x05, B=0x03 then yields diff=0x02.
REQ-034 Handshake: start toggled and A/B changed during RUN -> ignored, and the first result is unaffected.
  - With start held high, done pulses are spaced exactly 10 cycles apart.
